// File: rtl/exec_unit.sv
// exec_unit: execute stage between the register-file read ports and its write-back port.
// Latency: 1 cycle for ALU ops; WIDTH+1 edges from accept to result for the iterative MUL.
// Backpressure: in_ready drops for WIDTH cycles while a multiply iterates; otherwise one op per cycle.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid / in_ready      op handshake; op taken when both are high at a rising edge
//   op, rs_data, rt_data     opcode and the two operands (Read_Data, Read_Data2)
//   rd_in, wb_en_in          destination index and write-back request
//   ALU_WB, wb_rd, CNTRL_RS  registered result, destination and one-cycle write strobe
//   busy                     a multiply is iterating
//   illegal                  one-cycle pulse when an unsupported op is accepted
//
// Build option EXEC_MUL_EN: when defined, op 111 is a shift-add multiply.
// When undefined, op 111 completes in one cycle with a zero result, no
// write strobe, and an illegal pulse; busy is tied low.
module exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [4:0]       rd_in,
  input  logic             wb_en_in,
  output logic [WIDTH-1:0] ALU_WB,
  output logic [4:0]       wb_rd,
  output logic             CNTRL_RS,
  output logic             busy,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] w_alu;
  logic             w_accept;
  logic             w_wb_strobe;

  // Single-cycle result; MUL yields 0 here (its result comes from the iterator).
  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD: w_alu = rs_data + rt_data;
      OP_SUB: w_alu = rs_data - rt_data;
      OP_AND: w_alu = rs_data & rt_data;
      OP_OR:  w_alu = rs_data | rt_data;
      OP_XOR: w_alu = rs_data ^ rt_data;
      OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(rs_data) < $signed(rt_data))};
      OP_SLL: w_alu = rs_data << rt_data[SW-1:0];
      OP_MUL: w_alu = '0;
      default: w_alu = '0;
    endcase
  end

  // r0 is hardwired: never strobe a write to it.
  assign w_wb_strobe = wb_en_in && (rd_in != 5'd0);
  assign w_accept    = in_valid && in_ready;

`ifdef EXEC_MUL_EN

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SW-1:0]    r_cnt;
  logic [4:0]       r_rd;
  logic             r_wb_en;
  logic [WIDTH-1:0] w_acc_next;

  // The final add of the last iteration is folded into the write-back value.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign in_ready = !rst && (r_state == S_IDLE);
  assign busy     = (r_state == S_MUL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      ALU_WB   <= '0;
      wb_rd    <= '0;
      CNTRL_RS <= 1'b0;
      illegal  <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_wb_en  <= 1'b0;
    end else begin
      CNTRL_RS <= 1'b0;
      illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op == OP_MUL) begin
              r_mcand  <= rs_data;
              r_mplier <= rt_data;
              r_rd     <= rd_in;
              r_wb_en  <= wb_en_in;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else begin
              ALU_WB   <= w_alu;
              wb_rd    <= rd_in;
              CNTRL_RS <= w_wb_strobe;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == SW'(WIDTH - 1)) begin
            ALU_WB   <= w_acc_next;
            wb_rd    <= r_rd;
            CNTRL_RS <= r_wb_en && (r_rd != 5'd0);
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`else

  assign in_ready = !rst;
  assign busy     = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_WB   <= '0;
      wb_rd    <= '0;
      CNTRL_RS <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      CNTRL_RS <= 1'b0;
      illegal  <= 1'b0;
      if (w_accept) begin
        // w_alu is already 0 for op 111; it completes as a no-write op.
        ALU_WB <= w_alu;
        wb_rd  <= rd_in;
        if (op == OP_MUL) begin
          illegal <= 1'b1;
        end else begin
          CNTRL_RS <= w_wb_strobe;
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases then randomized ops,
// each compared against a behavioural arithmetic model of the result.
module tb_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic [4:0]   rd_in;
  logic         wb_en_in;
  logic [W-1:0] ALU_WB;
  logic [4:0]   wb_rd;
  logic         CNTRL_RS;
  logic         busy;
  logic         illegal;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_wb;
  logic [4:0]   exp_rd;

  exec_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .rd_in    (rd_in),
    .wb_en_in (wb_en_in),
    .ALU_WB   (ALU_WB),
    .wb_rd    (wb_rd),
    .CNTRL_RS (CNTRL_RS),
    .busy     (busy),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result computed directly from the op definitions.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd6: return a << (b % W);
`ifdef EXEC_MUL_EN
      default: return a * b;
`else
      default: return 0;
`endif
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the negedge where the result is visible.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic en);
    logic exp_str;
    logic exp_ill;
    int   n;
    logic rdy_bad;
    logic str_bad;
    check("ready_before_op", in_ready, 1);
    in_valid = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    rd_in    = rd;
    wb_en_in = en;
    @(posedge clk);
    @(negedge clk);
    exp_ill = 1'b0;
    exp_str = en && (rd != 0);
`ifdef EXEC_MUL_EN
    if (o == 3'd7) begin
      n       = 0;
      rdy_bad = 1'b0;
      str_bad = 1'b0;
      while (busy && n < 200) begin
        if (in_ready) rdy_bad = 1'b1;
        if (CNTRL_RS) str_bad = 1'b1;
        n++;
        @(negedge clk);
      end
      check("mul_busy_cycles", n, W);
      check("mul_ready_low_while_busy", rdy_bad, 0);
      check("mul_no_early_strobe", str_bad, 0);
    end
`else
    if (o == 3'd7) begin
      exp_ill = 1'b1;
      exp_str = 1'b0;
    end
`endif
    exp_wb = ref_alu(o, a, b);
    exp_rd = rd;
    check("result", ALU_WB, exp_wb);
    check("wb_rd", wb_rd, exp_rd);
    check("strobe", CNTRL_RS, exp_str);
    check("illegal", illegal, exp_ill);
    check("busy_after", busy, 0);
    check("ready_after", in_ready, 1);
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_strobe", CNTRL_RS, 0);
    check("idle_illegal", illegal, 0);
    check("idle_hold_wb", ALU_WB, exp_wb);
    check("idle_hold_rd", wb_rd, exp_rd);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wb"}, ALU_WB, 0);
    check({tag, "_rd"}, wb_rd, 0);
    check({tag, "_strobe"}, CNTRL_RS, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_ready"}, in_ready, 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = '0;
    rs_data  = '0;
    rt_data  = '0;
    rd_in    = '0;
    wb_en_in = 1'b0;
    exp_wb   = '0;
    exp_rd   = '0;

    // Reset held for two edges.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
    end
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    @(negedge clk);

    // ADD then SUB back-to-back, then idle to see the strobe drop.
    run_op(3'd0, 5, 7, 5'd3, 1'b1);
    check("add_value", ALU_WB, 12);
    run_op(3'd1, 0, 1, 5'd4, 1'b1);
    check("sub_value", ALU_WB, 32'hFFFF_FFFF);
    go_idle();

    // SLT, SLL with truncated shift amount, r0 write suppressed.
    run_op(3'd5, 32'hFFFF_FFFF, 1, 5'd6, 1'b1);
    check("slt_value", ALU_WB, 1);
    run_op(3'd6, 1, 32'h25, 5'd7, 1'b1);
    check("sll_value", ALU_WB, 32'h20);
    run_op(3'd0, 9, 9, 5'd0, 1'b1);
    check("r0_no_strobe", CNTRL_RS, 0);
    go_idle();

`ifdef EXEC_MUL_EN
    run_op(3'd7, 6, 7, 5'd9, 1'b1);
    check("mul_value", ALU_WB, 42);
    go_idle();
    run_op(3'd7, 32'hFFFF_FFFF, 2, 5'd10, 1'b1);
    check("mul_neg_value", ALU_WB, 32'hFFFF_FFFE);
    go_idle();

    // Reset ten cycles into a multiply: no write-back, outputs cleared.
    in_valid = 1'b1;
    op       = 3'd7;
    rs_data  = 3;
    rt_data  = 4;
    rd_in    = 5'd11;
    wb_en_in = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    check("mid_mul_busy", busy, 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("mid_mul_reset");
    rst = 1'b0;
    exp_wb = '0;
    exp_rd = '0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      check("mid_mul_no_strobe", CNTRL_RS, 0);
    end
    check("mid_mul_ready", in_ready, 1);
`else
    // Op 111 without the multiplier: one-cycle illegal, no stall.
    run_op(3'd7, 6, 7, 5'd5, 1'b1);
    check("nomul_wb", ALU_WB, 0);
    check("nomul_ready", in_ready, 1);
    go_idle();
`endif

    // Randomized ops with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      run_op(ro, ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
